dl_shift_seq: RTL and testbench
===============================

DL_SHIFT_SEQ -- requirements
Module: dl_shift_seq

Interface
REQ-001 SHALL have parameter NUM_BITS, default 32, operand/result width.
REQ-002 SHALL have parameter STEP_BITS, default 2, width of per-cycle step; STEP_MAX = 2^STEP_BITS - 1 bit positions per cycle.
REQ-003 SHALL derive localparam NUM_SHIFT_BITS = $clog2(NUM_BITS).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  request valid.
REQ-007 in_ready  output  1  sequencer can accept a request.
REQ-008 in_data  input  NUM_BITS  operand.
REQ-009 in_shamt  input  NUM_SHIFT_BITS  shift amount.
REQ-010 in_op  input  2  shift op: 00 SLL, 01 SRL, 11 SRA, 10 reserved (treated as SLL).
REQ-011 abort  input  1  cancel in-flight operation.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_data  output  NUM_BITS  shifted result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; acceptance = in_valid & in_ready at a rising edge.
REQ-018 On acceptance SHALL latch in_data, in_shamt (as remaining count), in_op; next state BUSY if in_shamt != 0, else DONE.
REQ-019 Each BUSY cycle SHALL apply step = min(remaining, STEP_MAX) to the data register and decrement remaining by step.
REQ-020 BUSY SHALL go to DONE on the edge where remaining becomes 0.
REQ-021 Latency: out_valid SHALL rise ceil(shamt/STEP_MAX) edges after the acceptance edge (0 extra edges for shamt 0).
REQ-022 SLL SHALL fill with 0 from LSB; SRL SHALL fill with 0 from MSB; SRA SHALL fill with latched operand bit NUM_BITS-1.
REQ-023 out_valid SHALL be 1 only in DONE; out_data SHALL hold the final result stable while out_valid=1 and out_ready=0.
REQ-024 DONE with out_ready=1 SHALL return to IDLE on that edge; no new request is accepted in the same cycle.
REQ-025 abort=1 in BUSY or DONE SHALL return to IDLE on the next edge, discarding the result; abort SHALL win over out_ready.
REQ-026 abort in IDLE SHALL be ignored, and SHALL block acceptance in that cycle (in_ready forced 0 while abort=1).
REQ-027 Input changes outside the acceptance edge SHALL NOT affect an in-flight operation.
REQ-028 shamt = NUM_BITS-1 SHALL complete correctly; remaining SHALL never underflow.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state IDLE, data register 0, remaining 0, op SLL.
REQ-030 During/after reset: in_ready=1 (when rst_n=1, abort=0), out_valid=0, out_data=0, busy=0.
REQ-031 Reset asserted mid-operation SHALL drop the operation; no out_valid after release.

Structure
REQ-032 Package dl_shift_pkg SHALL hold the shift-op enum (SLL/SRL/SRA codes) and the FSM state enum.
REQ-033 One sub-module dl_shift_step SHALL implement the combinational single-step shift (data, step amount, op -> data).
REQ-034 Data, remaining and op registers plus FSM SHALL reside in dl_shift_seq.

Verification (NUM_BITS=8, STEP_BITS=2, STEP_MAX=3)
REQ-035 SLL 0x01 shamt 7 -> out_valid 3 edges after accept, out_data 0x80.
REQ-036 SRA 0x80 shamt 5 -> out_valid 2 edges after accept, out_data 0xFC; SRL 0x80 shamt 5 -> 0x04.
REQ-037 shamt 0, data 0xA5 -> out_valid on edge after accept, out_data 0xA5; out_ready held 0 for 4 cycles -> out_data stable 0xA5, in_ready 0.
REQ-038 abort asserted 1 cycle into SLL shamt 7 -> IDLE next edge, out_valid never rises, in_ready=1 after abort deasserts.
REQ-039 rst_n pulsed low mid-BUSY -> immediate out_valid=0, busy=0, out_data=0; next request shamt 3 on 0x0F SLL -> 0x78.
REQ-040 Random ops/shamts with random in_valid/out_ready stalls -> every result matches reference shift, exactly one output per accepted request.

Source files
------------

// File: rtl/dl_shift_pkg.sv
// Shared types for the multi-cycle shift sequencer: shift-op codes and FSM states.
package dl_shift_pkg;

  // Shift operation codes as presented on in_op.
  // The reserved code behaves like a logical left shift.
  typedef enum logic [1:0] {
    OpSll = 2'b00,
    OpSrl = 2'b01,
    OpRsv = 2'b10,
    OpSra = 2'b11
  } shift_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/dl_shift_step.sv
// Combinational single step of the shift sequencer: shifts by at most 2^STEP_BITS-1 positions.
module dl_shift_step
  import dl_shift_pkg::*;
#(
  parameter int unsigned NUM_BITS  = 32,
  parameter int unsigned STEP_BITS = 2
) (
  input  logic [NUM_BITS-1:0]  data_in,
  input  logic [STEP_BITS-1:0] step,
  input  shift_op_e            op,
  output logic [NUM_BITS-1:0]  data_out
);

  // Arithmetic shifts keep the MSB unchanged, so the current MSB is always the
  // sign bit of the operand that was originally latched.
  always_comb begin
    case (op)
      OpSrl:   data_out = data_in >> step;
      OpSra:   data_out = $signed(data_in) >>> step;
      default: data_out = data_in << step;
    endcase
  end

endmodule

// File: rtl/dl_shift_seq.sv
// Multi-cycle shift sequencer: accepts one operand, shifts it a few positions per
// cycle, then presents the result with a valid/ready handshake.
module dl_shift_seq
  import dl_shift_pkg::*;
#(
  parameter int unsigned  NUM_BITS       = 32,
  parameter int unsigned  STEP_BITS      = 2,
  localparam int unsigned NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_BITS-1:0]       in_data,
  input  logic [NUM_SHIFT_BITS-1:0] in_shamt,
  input  logic [1:0]                in_op,
  input  logic                      abort,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_BITS-1:0]       out_data,
  output logic                      busy
);

  localparam int unsigned STEP_MAX = (2 ** STEP_BITS) - 1;

  state_e                    state_q, state_d;
  logic [NUM_BITS-1:0]       data_q, data_d;
  logic [NUM_SHIFT_BITS-1:0] rem_q, rem_d;
  shift_op_e                 op_q, op_d;

  logic [STEP_BITS-1:0]      step_amt;
  logic [NUM_SHIFT_BITS-1:0] rem_left;
  logic [NUM_BITS-1:0]       step_data;

  // Step size is min(remaining, STEP_MAX); since step <= remaining, no underflow.
  always_comb begin
    if (32'(rem_q) >= STEP_MAX) begin
      step_amt = STEP_BITS'(STEP_MAX);
    end else begin
      step_amt = STEP_BITS'(rem_q);
    end
    rem_left = rem_q - NUM_SHIFT_BITS'(step_amt);
  end

  dl_shift_step #(
    .NUM_BITS  (NUM_BITS),
    .STEP_BITS (STEP_BITS)
  ) u_step (
    .data_in  (data_q),
    .step     (step_amt),
    .op       (op_q),
    .data_out (step_data)
  );

  // Handshake outputs decode directly from state; abort masks acceptance.
  always_comb begin
    in_ready  = (state_q == StIdle) && !abort;
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    out_data  = data_q;
  end

  // Next-state logic: latch on acceptance, step while busy, hold result until taken.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          rem_d   = in_shamt;
          op_d    = shift_op_e'(in_op);
          state_d = (in_shamt != '0) ? StBusy : StDone;
        end
      end
      StBusy: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          data_d = step_data;
          rem_d  = rem_left;
          if (rem_left == '0) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // abort and out_ready both return to idle; the result is simply dropped on abort.
        if (abort || out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      rem_q   <= '0;
      op_q    <= OpSll;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_dl_shift_seq.sv
// Self-checking bench for dl_shift_seq with NUM_BITS=8, STEP_BITS=2.
module tb_dl_shift_seq;

  localparam int NB = 8;
  localparam int SB = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_data;
  logic [SB-1:0] in_shamt;
  logic [1:0]    in_op;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] out_data;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dl_shift_seq #(
    .NUM_BITS  (NB),
    .STEP_BITS (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  typedef struct {
    logic [1:0]    op;
    logic [NB-1:0] d;
    logic [SB-1:0] sh;
    logic [NB-1:0] exp;
    int            lat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: whole-amount shift with explicit sign fill, no stepping.
  function automatic logic [NB-1:0] ref_shift(input logic [NB-1:0] d, input logic [SB-1:0] s,
                                               input logic [1:0] op);
    logic [NB-1:0] ones;
    logic [NB-1:0] fill;
    ones = '1;
    fill = (op == 2'b11 && d[NB-1]) ? ~(ones >> s) : '0;
    if (op == 2'b01 || op == 2'b11) return (d >> s) | fill;
    return d << s;
  endfunction

  function automatic int ref_lat(input logic [SB-1:0] s);
    return (int'(s) + 2) / 3;
  endfunction

  // Present one request on a falling edge; it is accepted on the next rising edge.
  task automatic send(input logic [1:0] op, input logic [NB-1:0] d, input logic [SB-1:0] sh);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = sh;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = NB'($urandom);
    in_shamt = SB'($urandom);
    in_op    = 2'($urandom);
  endtask

  // Count rising edges after acceptance until out_valid; optionally jiggle inputs meanwhile.
  task automatic wait_valid(input bit rnd, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (rnd) begin
        @(negedge clk);
        out_ready = 1'($urandom);
        in_valid  = 1'($urandom);
        in_data   = NB'($urandom);
        in_shamt  = SB'($urandom);
        in_op     = 2'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    bit seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = 2'b00;
    abort     = 1'b0;
    out_ready = 1'b0;

    tbl[0]  = '{2'b00, 8'h01, 3'd7, 8'h80, 3};
    tbl[1]  = '{2'b11, 8'h80, 3'd5, 8'hFC, 2};
    tbl[2]  = '{2'b01, 8'h80, 3'd5, 8'h04, 2};
    tbl[3]  = '{2'b00, 8'hA5, 3'd0, 8'hA5, 0};
    tbl[4]  = '{2'b10, 8'h03, 3'd2, 8'h0C, 1};
    tbl[5]  = '{2'b01, 8'hF0, 3'd3, 8'h1E, 1};
    tbl[6]  = '{2'b11, 8'h7F, 3'd7, 8'h00, 3};
    tbl[7]  = '{2'b11, 8'h81, 3'd1, 8'hC0, 1};
    tbl[8]  = '{2'b00, 8'hFF, 3'd4, 8'hF0, 2};
    tbl[9]  = '{2'b01, 8'hFF, 3'd6, 8'h03, 2};
    tbl[10] = '{2'b11, 8'hC3, 3'd3, 8'hF8, 1};

    // Outputs while reset is held.
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      send(tbl[i].op, tbl[i].d, tbl[i].sh);
      wait_valid(1'b0, lat);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_data", i), {24'd0, out_data}, {24'd0, tbl[i].exp});
      consume();
      chk($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
    end

    // Result held under backpressure; new requests ignored while holding and on the taking edge.
    send(2'b00, 8'hA5, 3'd0);
    wait_valid(1'b0, lat);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h3C;
      in_shamt = 3'd2;
      @(posedge clk);
      #1;
      chk("hold_data", {24'd0, out_data}, 32'h0000_00A5);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("take_valid", {31'd0, out_valid}, 32'd0);
    chk("take_no_accept", {31'd0, busy}, 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b0;

    // Abort one cycle into a long shift.
    send(2'b00, 8'h01, 3'd7);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready_masked", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_in_ready_back", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_output", {31'd0, seen}, 32'd0);

    // Abort in idle blocks acceptance that cycle.
    @(negedge clk);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h11;
    in_shamt = 3'd1;
    in_op    = 2'b00;
    #1;
    chk("idle_abort_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("idle_abort_no_accept", {31'd0, busy}, 32'd0);
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;

    // Abort in DONE together with out_ready.
    send(2'b01, 8'hF0, 3'd0);
    @(negedge clk);
    abort     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("done_abort_valid", {31'd0, out_valid}, 32'd0);
    chk("done_abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    abort     = 1'b0;
    out_ready = 1'b0;

    // Reset pulse in the middle of a busy operation.
    send(2'b00, 8'h0F, 3'd7);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_data", {24'd0, out_data}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen = 1'b1;
    end
    chk("midrst_quiet", {31'd0, seen}, 32'd0);
    send(2'b00, 8'h0F, 3'd3);
    wait_valid(1'b0, lat);
    chk("postrst_lat", lat, 1);
    chk("postrst_data", {24'd0, out_data}, 32'h0000_0078);
    consume();

    // Randomized traffic with stalls, compared against the reference shift.
    for (int n = 0; n < 300; n++) begin
      logic [1:0]    op;
      logic [NB-1:0] d;
      logic [SB-1:0] sh;
      logic [NB-1:0] exp;
      bit            r;
      op = 2'($urandom);
      d  = NB'($urandom);
      sh = SB'($urandom);
      exp = ref_shift(d, sh, op);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      out_ready = 1'b0;
      send(op, d, sh);
      wait_valid(1'b1, lat);
      chk("rnd_lat", lat, ref_lat(sh));
      chk("rnd_data", {24'd0, out_data}, {24'd0, exp});
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        r = (k == 7) ? 1'b1 : 1'($urandom);
        out_ready = r;
        in_valid  = 1'($urandom);
        in_data   = NB'($urandom);
        @(posedge clk);
        #1;
        if (r) break;
        chk("rnd_hold", {24'd0, out_data}, {24'd0, exp});
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("rnd_single_output", {30'd0, out_valid, busy}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
